// File: rtl/ram_1p_pipe.sv
// ram_1p_pipe: single-port byte-enable RAM with zero-fill INIT, range checking and an optional output register.
module ram_1p_pipe #(
    parameter int unsigned DW        = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned AW        = $clog2(DEPTH),
    parameter bit          OUT_REG   = 1'b0,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    output logic            gnt_o,
    output logic            rvalid_o,
    output logic [DW-1:0]   rdata_o,
    output logic            err_o,
    output logic            init_done_o
);
    localparam int unsigned NB = DW / 8;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    if (DW % 8 != 0 || DW < 8 || DW > 128 || AW < $clog2(DEPTH)) begin : g_bad_param
        $error("ram_1p_pipe: DW must be a multiple of 8 in 8..128 and AW >= $clog2(DEPTH)");
    end

    typedef enum logic {INIT, READY} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            init_wr, in_range, mem_we;
    logic [IW-1:0]   idx, widx;
    logic [DW-1:0]   wdat;
    logic [NB-1:0]   wbe;
    logic [DW-1:0]   mem [DEPTH];
    logic            v1_q, v1_d, err1_q, err1_d;
    logic [DW-1:0]   rd1_q, rd1_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The fill counter stops at DEPTH because INIT is left on its last word.
    always_comb begin
        state_d = (state_q == READY || !INIT_ZERO || cnt_q == CW'(DEPTH - 1)) ? READY : INIT;
        cnt_d   = init_wr ? cnt_q + CW'(1) : cnt_q;
    end

    always_comb begin
        init_done_o = state_q == READY;
        gnt_o       = req_i && init_done_o;
        init_wr     = INIT_ZERO && state_q == INIT;
    end

    // Range check runs one bit wider so DEPTH == 2**AW cannot wrap to zero.
    always_comb begin
        in_range = {1'b0, addr_i} < (AW + 1)'(DEPTH);
        idx      = addr_i[IW-1:0];
        mem_we   = init_wr || (gnt_o && we_i && in_range);
        widx     = init_wr ? cnt_q[IW-1:0] : idx;
        wdat     = init_wr ? '0 : wdata_i;
        wbe      = init_wr ? '1 : be_i;
        v1_d     = gnt_o;
        err1_d   = gnt_o && !in_range;
        rd1_d    = (gnt_o && !we_i && in_range) ? mem[idx] : '0;
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++)
            if (mem_we && wbe[b]) mem[widx][8*b +: 8] <= wdat[8*b +: 8];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q   <= 1'b0;
            err1_q <= 1'b0;
            rd1_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            err1_q <= err1_d;
            rd1_q  <= rd1_d;
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic          v2_q, err2_q;
        logic [DW-1:0] rd2_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v2_q   <= 1'b0;
                err2_q <= 1'b0;
                rd2_q  <= '0;
            end else begin
                v2_q   <= v1_q;
                err2_q <= err1_q;
                rd2_q  <= rd1_q;
            end
        end
        assign rvalid_o = v2_q;
        assign err_o    = err2_q;
        assign rdata_o  = rd2_q;
    end else begin : g_out_dir
        assign rvalid_o = v1_q;
        assign err_o    = err1_q;
        assign rdata_o  = rd1_q;
    end
endmodule

// File: tb/tb_ram_1p_pipe.sv
// tb_ram_1p_pipe: drives one stimulus stream into OUT_REG=0 and OUT_REG=1 instances and scoreboards both.
module tb_ram_1p_pipe;
    localparam int DW = 32, DEPTH = 16, AW = 5;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
    } rsp_t;

    logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0;
    logic [3:0]  be = '0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  gnt, rvalid, err, done;
    logic [31:0] rdata [2];

    rsp_t        sbq [2][$];
    rsp_t        mon_h;
    logic [31:0] model [DEPTH];
    int          cyc = 0, rel = 0, checks = 0, errors = 0;

    always #5 clk = ~clk;

    ram_1p_pipe #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .OUT_REG(1'b0), .INIT_ZERO(1'b1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
        .err_o(err[0]), .init_done_o(done[0]));

    ram_1p_pipe #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .OUT_REG(1'b1), .INIT_ZERO(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
        .err_o(err[1]), .init_done_o(done[1]));

    always @(posedge clk) cyc <= cyc + 1;

    // Edges seen since reset release; the array is usable once DEPTH of them have passed.
    always @(posedge clk or negedge rst_n) rel <= !rst_n ? 0 : (rel < DEPTH ? rel + 1 : rel);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("init_done%0d", k), done[k], rel >= DEPTH);
            if (rvalid[k]) begin
                if (sbq[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp%0d: rvalid=1 at cycle %0d, expected no response", k, cyc);
                end else begin
                    mon_h = sbq[k].pop_front();
                    chk($sformatf("rdata%0d", k), rdata[k], mon_h.d);
                    chk($sformatf("err%0d", k), err[k], mon_h.e);
                    chk($sformatf("latency%0d", k), cyc, mon_h.due);
                end
            end else begin
                chk($sformatf("idle_out%0d", k), {err[k], rdata[k]}, 0);
                if (sbq[k].size() > 0 && sbq[k][0].due <= cyc) begin
                    mon_h = sbq[k].pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_rsp%0d: no rvalid at cycle %0d, expected response due at %0d", k, cyc, mon_h.due);
                end
            end
        end
    end

    task automatic issue(input logic r, input logic w, input logic [3:0] b, input logic [4:0] a,
                         input logic [31:0] d, output logic acc);
        rsp_t x;
        req = r; we = w; be = b; addr = a; wdata = d;
        @(negedge clk);
        acc = r && rel >= DEPTH;
        chk("gnt0", gnt[0], acc);
        chk("gnt1", gnt[1], acc);
        if (acc) begin
            x.e = a >= DEPTH;
            x.d = (!x.e && !w) ? model[a[3:0]] : 32'h0;
            if (!x.e && w)
                for (int i = 0; i < 4; i++) if (b[i]) model[a[3:0]][8*i +: 8] = d[8*i +: 8];
            x.due = cyc + 1;
            sbq[0].push_back(x);
            x.due = cyc + 2;
            sbq[1].push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a);
        logic g;
        issue(1'b1, 1'b0, 4'h0, a, 32'h0, g);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        logic g;
        issue(1'b1, 1'b1, b, a, d, g);
    endtask

    // Holds a read request until granted and returns how many cycles it was refused.
    task automatic read_until_granted(input logic [4:0] a, output int n);
        logic g;
        n = 0;
        g = 1'b0;
        while (!g && n <= 100) begin
            issue(1'b1, 1'b0, 4'h0, a, 32'h0, g);
            if (!g) n++;
        end
        if (!g) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: no grant after %0d cycles, expected one after %0d", n, DEPTH);
        end
    endtask

    task automatic random_traffic(input int count);
        logic g;
        repeat (count)
            issue($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, 4'($urandom),
                  5'($urandom_range(0, 31)), $urandom, g);
    endtask

    initial begin
        logic g;
        int   n;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        repeat (3) issue(1'b1, 1'b0, 4'h0, 5'd7, 32'h0, g);
        rst_n = 1'b1;
        read_until_granted(5'd7, n);
        chk("init_len", n, DEPTH);
        wr(5'd3, 32'hDEADBEEF, 4'hF);
        wr(5'd3, 32'h11223344, 4'h5);
        rd(5'd3);
        rd(5'd16);
        rd(5'd31);
        rd(5'd0);
        for (int i = 0; i < 8; i++) rd(5'(i));
        wr(5'd2, 32'hA5A5A5A5, 4'hF);
        wr(5'd2, 32'h12345678, 4'h0);
        rd(5'd2);
        random_traffic(400);
        rd(5'd5);
        rst_n = 1'b0;
        sbq[0].delete();
        sbq[1].delete();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        repeat (2) issue(1'b1, 1'b0, 4'h0, 5'd9, 32'h0, g);
        rst_n = 1'b1;
        read_until_granted(5'd9, n);
        chk("reinit_len", n, DEPTH);
        wr(5'd15, 32'hCAFEF00D, 4'hA);
        rd(5'd15);
        random_traffic(200);
        repeat (4) issue(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, g);
        chk("drain0", sbq[0].size(), 0);
        chk("drain1", sbq[1].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
